// File: rtl/matrix_sub_unit.sv
// Streams an n-by-n matrix subtraction, one element pair at a time.
// Each accepted (a, b) pair produces a registered difference with a signed
// overflow flag. A one-entry output register gives full throughput under
// backpressure. The per-operation status is kept in two sticky flags:
// ovf_any, and err_size for an illegal start request.
module matrix_sub_unit #(
  parameter int DW    = 8,
  parameter int MAX_N = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    size,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] diff,
  output logic          ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          ovf_any,
  output logic          err_size
);

  localparam int CW = $clog2(MAX_N * MAX_N + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] total;
  logic [CW-1:0] cnt;
  logic [5:0]    sq;
  logic          legal;
  logic          in_hs;
  logic          out_hs;
  logic          last_in;
  logic [DW-1:0] res;
  logic          res_ovf;

  assign sq      = {3'b000, size} * {3'b000, size};
  assign legal   = (size != 3'd0) && (int'(size) <= MAX_N);
  assign res     = a - b;
  assign res_ovf = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_in  = in_hs && (cnt == total - ONE);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: run until the last pair is accepted, drain it, then pulse done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = legal ? RUN : FIN;
      RUN:     if (last_in) state_nxt = DRAIN;
      DRAIN:   if (out_hs) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the request, count pairs, hold or replace the output register, and collect sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      total     <= '0;
      cnt       <= '0;
      diff      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      ovf_any   <= 1'b0;
      err_size  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        ovf_any <= 1'b0;
        if (legal) begin
          total    <= CW'(sq);
          cnt      <= '0;
          err_size <= 1'b0;
        end else begin
          err_size <= 1'b1;
        end
      end
      if (in_hs) begin
        diff      <= res;
        ovf       <= res_ovf;
        out_valid <= 1'b1;
        cnt       <= cnt + ONE;
        ovf_any   <= ovf_any | res_ovf;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_sub_unit.sv
// Scoreboard bench for matrix_sub_unit. The driver issues operations and
// queues the expected results. A monitor pops the queue on every output
// handshake and checks the popped value.
module tb_matrix_sub_unit;

  localparam int DW    = 8;
  localparam int MAX_N = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    size;
  logic [DW-1:0] a, b;
  logic          in_valid, in_ready;
  logic [DW-1:0] diff;
  logic          ovf, out_valid, out_ready;
  logic          busy, done, ovf_any, err_size;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          o;
  } exp_t;

  exp_t sbq[$];
  int   dirA[$];
  int   dirB[$];

  int            checks = 0;
  int            passes = 0;
  int            outCount = 0;
  logic          stalled = 1'b0;
  logic [DW-1:0] lastDiff;
  logic          lastOvf;

  matrix_sub_unit #(.DW(DW), .MAX_N(MAX_N)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .diff(diff), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .ovf_any(ovf_any), .err_size(err_size)
  );

  always #5 clk = ~clk;

  // Reference model: signed subtraction in plain integers, wrapped to DW bits.
  function automatic exp_t refSub(input int ai, input int bi);
    exp_t e;
    int   d;
    d   = ai - bi;
    e.o = (d < -(1 << (DW - 1))) || (d > (1 << (DW - 1)) - 1);
    e.d = DW'(d);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: checks each output handshake against the scoreboard, and checks that outputs stay stable while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (stalled) begin
        checkOutput("holdDiff", int'(diff), int'(lastDiff));
        checkOutput("holdOvf", int'(ovf), int'(lastOvf));
      end
      if (out_valid && out_ready) begin
        checkOutput("sbNotEmpty", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checkOutput("diff", int'(diff), int'(e.d));
          checkOutput("ovf", int'(ovf), int'(e.o));
        end
        outCount++;
      end
      stalled  = out_valid && !out_ready;
      lastDiff = diff;
      lastOvf  = ovf;
    end else begin
      stalled = 1'b0;
    end
  end

  // One operation of size n.
  // readyMode: 0 = always ready, 1 = random, 2 = stall 4 cycles after the first result.
  // glitch: pulses start with a different size in mid-run.
  // resetAfter: when > 0, reset after that many accepted pairs.
  task automatic applyStimulus(input int n, input int readyMode, input bit glitch, input int resetAfter);
    int   acc = 0;
    int   cyc = 0;
    int   idx = 0;
    int   stall = 0;
    int   ai, bi;
    bit   ovfAll = 0;
    bit   prevHs = 0;
    bit   stallUsed = 0;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; size = 3'(n);
    @(posedge clk); #1;
    start = 1'b0;
    outCount = 0;
    forever begin
      if (idx < dirA.size()) begin ai = dirA[idx]; bi = dirB[idx]; end
      else begin ai = int'($urandom_range(0, 255)) - 128; bi = int'($urandom_range(0, 255)) - 128; end
      a = DW'(ai); b = DW'(bi);
      in_valid = (readyMode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (readyMode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else if (stall > 0) begin out_ready = 1'b0; stall--; end
      else out_ready = 1'b1;
      if (glitch && cyc == 2) begin start = 1'b1; size = 3'((n % MAX_N) + 1); end
      else start = 1'b0;
      if (resetAfter > 0 && acc == resetAfter) begin
        rst = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstDiff", int'(diff), 0);
        checkOutput("rstOvf", int'(ovf), 0);
        checkOutput("rstOutValid", int'(out_valid), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstOvfAny", int'(ovf_any), 0);
        checkOutput("rstErrSize", int'(err_size), 0);
        checkOutput("rstInReady", int'(in_ready), 0);
        checkOutput("rstBusy", int'(busy), 0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        dirA.delete(); dirB.delete();
        return;
      end
      @(negedge clk);
      if (prevHs) checkOutput("latency", int'(out_valid), 1);
      checkOutput("inReady", int'(in_ready), int'((acc < n * n) && (!out_valid || out_ready)));
      prevHs = in_valid && in_ready;
      if (prevHs) begin
        e = refSub(ai, bi);
        sbq.push_back(e);
        ovfAll |= e.o;
        acc++;
        idx++;
      end
      if (readyMode == 2 && out_valid && !stallUsed) begin stall = 4; stallUsed = 1; end
      if (done) begin
        checkOutput("acceptedCount", acc, n * n);
        checkOutput("outputCount", outCount, n * n);
        checkOutput("sbEmpty", sbq.size(), 0);
        checkOutput("ovfAny", int'(ovf_any), int'(ovfAll));
        checkOutput("errSizeClear", int'(err_size), 0);
        @(negedge clk);
        checkOutput("donePulse", int'(done), 0);
        checkOutput("idleBusy", int'(busy), 0);
        @(negedge clk);
        checkOutput("ovfAnyHold", int'(ovf_any), int'(ovfAll));
        break;
      end
      cyc++;
      if (cyc > 3000) begin
        checkOutput("doneSeen", int'(done), 1);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    dirA.delete(); dirB.delete();
  endtask

  // Start with an illegal size: expect err_size, no input acceptance, and an immediate done pulse.
  task automatic applyBadStart(input int n);
    @(posedge clk); #1;
    start = 1'b1; size = 3'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("badErrSize", int'(err_size), 1);
    checkOutput("badDone", int'(done), 1);
    checkOutput("badInReady", int'(in_ready), 0);
    checkOutput("badOvfAny", int'(ovf_any), 0);
    @(negedge clk);
    checkOutput("badDoneEnd", int'(done), 0);
    checkOutput("badBusy", int'(busy), 0);
    checkOutput("badErrSticky", int'(err_size), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; size = '0; a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetOutValid", int'(out_valid), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);
    checkOutput("resetInReady", int'(in_ready), 0);
    checkOutput("resetDiff", int'(diff), 0);
    checkOutput("resetFlags", int'({ovf_any, err_size, ovf}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    dirA = '{10, 0, -128, 127};
    dirB = '{3, 1, 1, -1};
    applyStimulus(2, 0, 0, 0);

    applyStimulus(3, 2, 0, 0);

    applyBadStart(0);
    applyBadStart(6);
    applyBadStart(7);

    applyStimulus(4, 1, 0, 3);
    applyStimulus(1, 0, 0, 0);

    applyStimulus(3, 0, 1, 0);

    for (int i = 0; i < 6; i++) applyStimulus(int'($urandom_range(1, MAX_N)), 1, 0, 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/matrix_sub_unit.md
MATRIX_SUB_UNIT -- requirements
Module: matrix_sub_unit

Interface
REQ-001 The block SHALL have parameter DW, default 8, element width in bits.
REQ-002 The block SHALL have parameter MAX_N, default 5, largest supported matrix dimension.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to begin a matrix subtraction; sampled only in IDLE.
REQ-007 size  input  3  matrix dimension n; sampled with start; element count = n*n.
REQ-008 a  input  DW  minuend element, two's complement.
REQ-009 b  input  DW  subtrahend element, two's complement.
REQ-010 in_valid  input  1  a/b pair valid.
REQ-011 in_ready  output  1  block accepts a/b this cycle.
REQ-012 diff  output  DW  registered result a-b.
REQ-013 ovf  output  1  signed overflow of the element currently on diff.
REQ-014 out_valid  output  1  diff/ovf valid.
REQ-015 out_ready  input  1  consumer accepts diff/ovf this cycle.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse at end of operation.
REQ-018 ovf_any  output  1  sticky OR of all ovf in current operation.
REQ-019 err_size  output  1  sticky flag: last start had an illegal size.

Function
REQ-020 States SHALL be IDLE, RUN, DRAIN, FIN.
REQ-021 IDLE: start=1 with 1<=size<=MAX_N SHALL latch total=size*size, clear element counter, ovf_any and err_size, and go to RUN next cycle.
REQ-022 IDLE: start=1 with size=0 or size>MAX_N SHALL set err_size, clear ovf_any, and go to FIN (zero elements processed).
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 in_ready SHALL equal (state==RUN) and (out_valid==0 or out_ready==1).
REQ-025 Input handshake: in_valid and in_ready high in same cycle; each handshake increments the element counter by one.
REQ-026 On input handshake, diff SHALL load (a-b) mod 2^DW and out_valid SHALL be 1 the next cycle (latency 1).
REQ-027 ovf SHALL be 1 when a[DW-1]!=b[DW-1] and result[DW-1]!=a[DW-1]; ovf_any SHALL OR it in on the same edge.
REQ-028 While out_valid=1 and out_ready=0, diff and ovf SHALL hold stable.
REQ-029 Output handshake without simultaneous input handshake SHALL clear out_valid; simultaneous output and input handshake SHALL load the new result with out_valid staying 1 (full throughput, one element per cycle).
REQ-030 RUN: the handshake accepting element number total SHALL move the state to DRAIN; no further inputs accepted.
REQ-031 DRAIN: the output handshake of the last element SHALL move the state to FIN.
REQ-032 FIN: done SHALL be 1 for exactly this one cycle; next state IDLE.
REQ-033 ovf_any and err_size SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-034 rst=1 SHALL force state IDLE, counter 0, diff 0, ovf 0, out_valid 0, done 0, ovf_any 0, err_size 0, in_ready 0, busy 0 at the next edge, including mid-operation; pending elements are discarded.
REQ-035 rst SHALL take priority over start and all handshakes in the same cycle.

Verification
REQ-036 start, size=2, out_ready=1, pairs (10,3),(0,1),(-128,1),(127,-1) back-to-back -> diff 7,255,127,128 on consecutive cycles; ovf 0,0,1,1; ovf_any=1; done one cycle after last output.
REQ-037 size=3, out_ready held 0 for 4 cycles after first result -> in_ready=0, diff stable, no element lost; 9 results total, then done.
REQ-038 start with size=0 and with size=6 -> err_size=1, no in_ready, done pulse 1 cycle after start, back in IDLE.
REQ-039 rst asserted in RUN after 3 of 16 elements (size=4) -> all outputs 0 next cycle; new start size=1 completes normally with 1 result.
REQ-040 start pulsed during RUN with a different size -> ignored; element count stays the originally latched total.
